aes_cipher_iter: RTL and testbench



---
 rtl/aes_cipher_iter_if.sv | 23 ++
 rtl/aes_cipher_iter.sv | 159 +++++++++++++++
 tb/tb_aes_cipher_iter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/aes_cipher_iter_if.sv
// Block handshake bundle for aes_cipher_iter: plaintext/key in, ciphertext out,
// each side with its own valid/ready pair.
interface aes_cipher_iter_if #(
   parameter int KEY_BITS = 128
);
   logic                in_valid;
   logic                in_ready;
   logic [127:0]        plain_text;
   logic [KEY_BITS-1:0] cipher_key;
   logic                out_valid;
   logic                out_ready;
   logic [127:0]        cipher_text;

   modport master (
      output in_valid, plain_text, cipher_key, out_ready,
      input  in_ready, out_valid, cipher_text
   );

   modport slave (
      input  in_valid, plain_text, cipher_key, out_ready,
      output in_ready, out_valid, cipher_text
   );
endinterface

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core (128/192/256-bit keys), one round per clock,
// with on-the-fly key expansion from an Nk-word sliding window.
module aes_cipher_iter #(
   parameter int KEY_BITS = 128
) (
   input  logic             clk,
   input  logic             rst,
   aes_cipher_iter_if.slave bus
);
   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;

   generate
      if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
         $error("aes_cipher_iter: KEY_BITS must be 128, 192 or 256");
      end
   endgenerate

   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Byte n of the state sits at [127-8n]; column c holds bytes 4c..4c+3.
   function automatic logic [127:0] aes_round(input logic [127:0] s,
                                              input logic [127:0] rk,
                                              input logic         last);
      logic [7:0]   sb [16];
      logic [127:0] sr;
      logic [127:0] mc;
      for (int n = 0; n < 16; n++) sb[n] = sbox(s[127 - 8 * n -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[127 - 8 * (4 * c + r) -: 8] = sb[4 * ((c + r) % 4) + r];
      for (int c = 0; c < 4; c++) mc[127 - 32 * c -: 32] = mix_col(sr[127 - 32 * c -: 32]);
      return (last ? sr : mc) ^ rk;
   endfunction

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t       state_q, state_d;
   logic [127:0] st_q;
   logic [31:0]  win_q [NK];
   logic [7:0]   rcon_q;
   logic [3:0]   cnt_q;
   logic [2:0]   gpos_q;

   logic         in_ready_c, out_valid_c;
   logic         accept;
   logic         last_round;
   logic [31:0]  ext [NK + 4];
   logic [31:0]  sub_in, sub_out;
   logic         rot_en, rcon_use;
   logic [127:0] rk, rnd_out;
   logic [2:0]   gpos_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_d = ROUND;
         end
         ROUND: if (last_round) state_d = DONE;
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_c;
   assign bus.cipher_text = st_q;
   assign accept          = in_ready_c & bus.in_valid;
   assign last_round      = (cnt_q == 4'(NR));

   // Key expansion: ext[0..NK-1] is the window (w[g-NK..g-1]), ext[NK..NK+3] the
   // four words generated this cycle. gpos_q tracks g mod NK. The only SubWord in
   // a 192-bit group at gpos 4 lands on word 2, whose input folds back to window
   // words, so the single shared SubWord never depends on its own output.
   always_comb begin
      for (int j = 0; j < NK + 4; j++) ext[j] = '0;
      for (int j = 0; j < NK; j++) ext[j] = win_q[j];
      sub_in   = (NK == 6 && gpos_q == 3'd4) ? (win_q[0] ^ win_q[1] ^ win_q[NK-1]) : win_q[NK-1];
      rot_en   = !(NK == 8 && gpos_q == 3'd4);
      sub_out  = sub_word(rot_en ? {sub_in[23:0], sub_in[31:24]} : sub_in);
      rcon_use = (gpos_q == 3'd0) || (NK == 6 && gpos_q == 3'd4);
      for (int k = 0; k < 4; k++) begin
         if ((int'(gpos_q) + k) % NK == 0)
            ext[NK + k] = ext[k] ^ sub_out ^ {rcon_q, 24'h000000};
         else if (NK == 8 && (int'(gpos_q) + k) % NK == 4)
            ext[NK + k] = ext[k] ^ sub_out;
         else
            ext[NK + k] = ext[k] ^ ext[NK + k - 1];
      end
      rk       = {ext[4], ext[5], ext[6], ext[7]};
      gpos_nxt = 3'((int'(gpos_q) + 4) % NK);
   end

   assign rnd_out = aes_round(st_q, rk, last_round);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= '0;
         rcon_q <= 8'h01;
         cnt_q  <= '0;
         gpos_q <= '0;
         for (int j = 0; j < NK; j++) win_q[j] <= '0;
      end else if (accept) begin
         st_q   <= bus.plain_text ^ bus.cipher_key[KEY_BITS-1 -: 128];
         rcon_q <= 8'h01;
         cnt_q  <= 4'd1;
         gpos_q <= '0;
         for (int j = 0; j < NK; j++) win_q[j] <= bus.cipher_key[KEY_BITS - 1 - 32 * j -: 32];
      end else if (state_q == ROUND) begin
         st_q   <= rnd_out;
         gpos_q <= gpos_nxt;
         if (rcon_use)    rcon_q <= xtime(rcon_q);
         if (!last_round) cnt_q  <= cnt_q + 4'd1;
         for (int j = 0; j < NK; j++) win_q[j] <= ext[j + 4];
      end
   end
endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed-vector bench for aes_cipher_iter: FIPS-197 vectors at all three key
// sizes, back-to-back issue, backpressure, input stability and mid-block reset.
module tb_aes_cipher_iter;
   localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [191:0] KEY3 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] CT3  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [255:0] KEY4 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT4  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   aes_cipher_iter_if #(.KEY_BITS(128)) if128 ();
   aes_cipher_iter_if #(.KEY_BITS(192)) if192 ();
   aes_cipher_iter_if #(.KEY_BITS(256)) if256 ();

   aes_cipher_iter #(.KEY_BITS(128)) dut128 (.clk(clk), .rst(rst), .bus(if128));
   aes_cipher_iter #(.KEY_BITS(192)) dut192 (.clk(clk), .rst(rst), .bus(if192));
   aes_cipher_iter #(.KEY_BITS(256)) dut256 (.clk(clk), .rst(rst), .bus(if256));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue128(input logic [127:0] pt, input logic [127:0] key);
      if128.in_valid   = 1'b1;
      if128.plain_text = pt;
      if128.cipher_key = key;
      step();
      if128.in_valid   = 1'b0;
   endtask

   // Counts edges after the accept edge until out_valid; scrambles inputs if asked.
   task automatic wait_out128(input bit scramble, output int lat);
      lat = 0;
      while (if128.out_valid !== 1'b1 && lat < 40) begin
         if (scramble) begin
            if128.plain_text = {$urandom, $urandom, $urandom, $urandom};
            if128.cipher_key = {$urandom, $urandom, $urandom, $urandom};
         end
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if (if128.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", if128.in_ready); end
      total++; if (if128.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", if128.out_valid); end
      total++; if (if128.cipher_text !== 128'h0) begin bad++; $display("FAIL reset_ct: got %h expected 0", if128.cipher_text); end
      total++; if (if256.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_256: got %b expected 1", if256.in_ready); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_fips128();
      int lat;
      if128.out_ready = 1'b1;
      issue128(PT1, KEY1);
      wait_out128(1'b0, lat);
      total++; if (lat !== 10) begin bad++; $display("FAIL fips128_latency: got %0d expected 10", lat); end
      total++; if (if128.cipher_text !== CT1) begin bad++; $display("FAIL fips128_ct: got %h expected %h", if128.cipher_text, CT1); end
      step();
      total++; if (if128.out_valid !== 1'b0) begin bad++; $display("FAIL fips128_one_cycle_valid: got %b expected 0", if128.out_valid); end
      total++; if (if128.in_ready !== 1'b1) begin bad++; $display("FAIL fips128_ready_after_hs: got %b expected 1", if128.in_ready); end
   endtask

   task automatic test_back_to_back();
      int lat;
      issue128(PT2, KEY2);
      wait_out128(1'b0, lat);
      total++; if (lat !== 10) begin bad++; $display("FAIL b2b_latency: got %0d expected 10", lat); end
      total++; if (if128.cipher_text !== CT2) begin bad++; $display("FAIL b2b_ct: got %h expected %h", if128.cipher_text, CT2); end
      step();
      total++; if (if128.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_hs: got %b expected 1", if128.in_ready); end
   endtask

   task automatic test_aes192();
      int lat = 0;
      if192.out_ready  = 1'b1;
      if192.in_valid   = 1'b1;
      if192.plain_text = PT2;
      if192.cipher_key = KEY3;
      step();
      if192.in_valid   = 1'b0;
      while (if192.out_valid !== 1'b1 && lat < 40) begin step(); lat++; end
      total++; if (lat !== 12) begin bad++; $display("FAIL aes192_latency: got %0d expected 12", lat); end
      total++; if (if192.cipher_text !== CT3) begin bad++; $display("FAIL aes192_ct: got %h expected %h", if192.cipher_text, CT3); end
      step();
      total++; if (if192.in_ready !== 1'b1) begin bad++; $display("FAIL aes192_ready_after_hs: got %b expected 1", if192.in_ready); end
   endtask

   task automatic test_aes256();
      int lat = 0;
      if256.out_ready  = 1'b1;
      if256.in_valid   = 1'b1;
      if256.plain_text = PT2;
      if256.cipher_key = KEY4;
      step();
      if256.in_valid   = 1'b0;
      while (if256.out_valid !== 1'b1 && lat < 40) begin step(); lat++; end
      total++; if (lat !== 14) begin bad++; $display("FAIL aes256_latency: got %0d expected 14", lat); end
      total++; if (if256.cipher_text !== CT4) begin bad++; $display("FAIL aes256_ct: got %h expected %h", if256.cipher_text, CT4); end
      step();
      total++; if (if256.out_valid !== 1'b0) begin bad++; $display("FAIL aes256_valid_after_hs: got %b expected 0", if256.out_valid); end
   endtask

   task automatic test_backpressure();
      int lat;
      if128.out_ready = 1'b0;
      issue128(PT1, KEY1);
      wait_out128(1'b0, lat);
      total++; if (lat !== 10) begin bad++; $display("FAIL bp_latency: got %0d expected 10", lat); end
      for (int i = 0; i < 20; i++) begin
         if128.in_valid   = 1'b1;
         if128.plain_text = PT2;
         if128.cipher_key = KEY2;
         step();
         total++; if (if128.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_held[%0d]: got %b expected 1", i, if128.out_valid); end
         total++; if (if128.cipher_text !== CT1) begin bad++; $display("FAIL bp_ct_stable[%0d]: got %h expected %h", i, if128.cipher_text, CT1); end
         total++; if (if128.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, if128.in_ready); end
      end
      if128.in_valid  = 1'b0;
      if128.out_ready = 1'b1;
      step();
      total++; if (if128.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b expected 0", if128.out_valid); end
      total++; if (if128.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b expected 1", if128.in_ready); end
      for (int i = 0; i < 14; i++) begin
         step();
         total++; if (if128.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_ghost_block[%0d]: got %b expected 0", i, if128.out_valid); end
      end
   endtask

   task automatic test_input_stability();
      int lat;
      if128.out_ready = 1'b1;
      issue128(PT2, KEY2);
      wait_out128(1'b1, lat);
      total++; if (lat !== 10) begin bad++; $display("FAIL stab_latency: got %0d expected 10", lat); end
      total++; if (if128.cipher_text !== CT2) begin bad++; $display("FAIL stab_ct: got %h expected %h", if128.cipher_text, CT2); end
      step();
   endtask

   task automatic test_reset_mid_round();
      int lat;
      if128.out_ready = 1'b1;
      issue128(PT1, KEY1);
      repeat (5) step();
      total++; if (if128.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b expected 0", if128.in_ready); end
      rst = 1'b1;
      #1;
      total++; if (if128.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b expected 0", if128.out_valid); end
      total++; if (if128.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b expected 1", if128.in_ready); end
      total++; if (if128.cipher_text !== 128'h0) begin bad++; $display("FAIL midrst_ct: got %h expected 0", if128.cipher_text); end
      step();
      rst = 1'b0;
      repeat (8) step();
      total++; if (if128.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_discarded: got %b expected 0", if128.out_valid); end
      issue128(PT2, KEY2);
      wait_out128(1'b0, lat);
      total++; if (lat !== 10) begin bad++; $display("FAIL midrst_fresh_latency: got %0d expected 10", lat); end
      total++; if (if128.cipher_text !== CT2) begin bad++; $display("FAIL midrst_fresh_ct: got %h expected %h", if128.cipher_text, CT2); end
      step();
   endtask

   initial begin
      rst = 1'b1;
      if128.in_valid = 1'b0; if128.out_ready = 1'b0; if128.plain_text = '0; if128.cipher_key = '0;
      if192.in_valid = 1'b0; if192.out_ready = 1'b0; if192.plain_text = '0; if192.cipher_key = '0;
      if256.in_valid = 1'b0; if256.out_ready = 1'b0; if256.plain_text = '0; if256.cipher_key = '0;
      test_reset();
      test_fips128();
      test_back_to_back();
      test_aes192();
      test_aes256();
      test_backpressure();
      test_input_stability();
      test_reset_mid_round();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
